// File: rtl/led_counter_ctrl.sv
// ============================================================================
//  Module      : led_counter_ctrl
//  Description : Programmable clock divider driving an up/down LED counter.
//                A three-state controller (IDLE / RUN / HOLD) gates the
//                divider. Divider terminal value and count direction are
//                loaded through a valid/ready handshake, which is accepted
//                only while the counter is not running.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_counter_ctrl #(
   parameter int                CNT_W       = 8,
   parameter int                DIV_W       = 17,
   parameter logic [DIV_W-1:0]  DEFAULT_DIV = 17'd99999
) (
   input  logic              clk,
   input  logic              rst,        // asynchronous, active-low
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic              cfg_dir,    // 1 = count up, 0 = count down
   input  logic              start,
   input  logic              stop,
   input  logic              clear,
   output logic              tick,
   output logic [CNT_W-1:0]  leds,
   output logic              wrap,
   output logic              running
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t             state_q,   state_d;
   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic [DIV_W-1:0]   div_reg_q, div_reg_d;
   logic               dir_reg_q, dir_reg_d;
   logic [CNT_W-1:0]   leds_q,    leds_d;
   logic               tick_q,    tick_d;
   logic               wrap_q,    wrap_d;
   logic               running_q, running_d;
   logic               cfg_xfer;

   // Configuration is only writable while the divider is not advancing
   assign cfg_ready = (state_q != RUN);
   assign cfg_xfer  = cfg_valid & cfg_ready;

   // Next-state and datapath: clear dominates, then stop, then start
   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      div_reg_d = div_reg_q;
      dir_reg_d = dir_reg_q;
      leds_d    = leds_q;
      tick_d    = 1'b0;
      wrap_d    = 1'b0;

      if (clear) begin
         // Configuration registers survive a clear; only the run state resets
         state_d   = IDLE;
         div_cnt_d = '0;
         leds_d    = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (stop) begin
                  // Pause: divider position is frozen so a later start resumes
                  state_d = HOLD;
               end else if (div_cnt_q == div_reg_q) begin
                  div_cnt_d = '0;
                  tick_d    = 1'b1;
                  if (dir_reg_q) begin
                     leds_d = leds_q + CNT_W'(1);
                     wrap_d = (leds_q == {CNT_W{1'b1}});
                  end else begin
                     leds_d = leds_q - CNT_W'(1);
                     wrap_d = (leds_q == '0);
                  end
               end else begin
                  div_cnt_d = div_cnt_q + DIV_W'(1);
               end
            end
            IDLE, HOLD: begin
               if (cfg_xfer) begin
                  div_reg_d = cfg_div;
                  dir_reg_d = cfg_dir;
                  div_cnt_d = '0;
               end
               if (start) begin
                  state_d = RUN;
                  // From IDLE a run always starts a fresh period; HOLD resumes
                  if (state_q == IDLE) begin
                     div_cnt_d = '0;
                  end
               end
            end
            default: begin
               state_d   = IDLE;
               div_cnt_d = '0;
            end
         endcase
      end

      running_d = (state_d == RUN);
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt_q <= '0;
         div_reg_q <= DEFAULT_DIV;
         dir_reg_q <= 1'b1;
         leds_q    <= '0;
         tick_q    <= 1'b0;
         wrap_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         div_reg_q <= div_reg_d;
         dir_reg_q <= dir_reg_d;
         leds_q    <= leds_d;
         tick_q    <= tick_d;
         wrap_q    <= wrap_d;
         running_q <= running_d;
      end
   end

   assign tick    = tick_q;
   assign leds    = leds_q;
   assign wrap    = wrap_q;
   assign running = running_q;

endmodule

`default_nettype wire

// File: tb/tb_led_counter_ctrl.sv
// ============================================================================
//  Module      : tb_led_counter_ctrl
//  Description : Directed-vector bench for led_counter_ctrl. Inputs change
//                and outputs are sampled on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_counter_ctrl;

   localparam int               CNT_W = 8;
   localparam int               DIV_W = 17;
   localparam logic [DIV_W-1:0] DDIV  = 17'd99999;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [DIV_W-1:0]  cfg_div;
   logic              cfg_dir;
   logic              start;
   logic              stop;
   logic              clear;
   logic              tick;
   logic [CNT_W-1:0]  leds;
   logic              wrap;
   logic              running;

   int n_vec = 0;
   int n_err = 0;

   led_counter_ctrl #(
      .CNT_W       (CNT_W),
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DDIV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_div   (cfg_div),
      .cfg_dir   (cfg_dir),
      .start     (start),
      .stop      (stop),
      .clear     (clear),
      .tick      (tick),
      .leds      (leds),
      .wrap      (wrap),
      .running   (running)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge; return at the following falling edge
   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      cfg_valid = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      clear     = 1'b0;
   endtask

   initial begin
      rst     = 1'b0;
      cfg_div = '0;
      cfg_dir = 1'b1;
      idle_inputs();
      #12;
      // ---------------- reset values
      chk("rst_leds",    32'(leds),    32'd0);
      chk("rst_tick",    32'(tick),    32'd0);
      chk("rst_wrap",    32'(wrap),    32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_ready",   32'(cfg_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      step();
      chk("post_rst_running", 32'(running), 32'd0);

      // ---------------- config div=3 up together with start
      cfg_valid = 1'b1; cfg_div = 17'd3; cfg_dir = 1'b1; start = 1'b1;
      step();
      idle_inputs();
      chk("run1_running", 32'(running),   32'd1);
      chk("run1_ready",   32'(cfg_ready), 32'd0);
      for (int i = 1; i <= 12; i++) begin
         step();
         chk("run1_tick", 32'(tick), 32'((i % 4) == 0));
         chk("run1_leds", 32'(leds), 32'(i / 4));
      end

      // ---------------- config attempt while running is ignored
      cfg_valid = 1'b1; cfg_div = 17'd7; cfg_dir = 1'b0;
      chk("busy_ready", 32'(cfg_ready), 32'd0);
      start = 1'b1;   // start in RUN is ignored as well
      step();
      idle_inputs();
      chk("busy_tick", 32'(tick), 32'd0);
      for (int i = 2; i <= 4; i++) begin
         step();
         chk("busy_tick", 32'(tick), 32'(i == 4));
      end
      chk("busy_leds", 32'(leds), 32'd4);

      // ---------------- stop and clear together on a would-be tick edge
      step(); step(); step();
      chk("pre_clr_tick", 32'(tick), 32'd0);
      stop = 1'b1; clear = 1'b1;
      step();
      idle_inputs();
      chk("clr_running", 32'(running),   32'd0);
      chk("clr_leds",    32'(leds),      32'd0);
      chk("clr_tick",    32'(tick),      32'd0);
      chk("clr_ready",   32'(cfg_ready), 32'd1);

      // ---------------- HOLD with div_cnt=2, reconfig resets divider
      cfg_valid = 1'b1; cfg_div = 17'd5; cfg_dir = 1'b1; start = 1'b1;
      step();
      idle_inputs();
      step(); step();                // div_cnt = 2
      stop = 1'b1;
      step();
      idle_inputs();
      chk("hold_running", 32'(running),   32'd0);
      chk("hold_tick",    32'(tick),      32'd0);
      chk("hold_ready",   32'(cfg_ready), 32'd1);
      stop = 1'b1;                   // stop in HOLD is ignored
      cfg_valid = 1'b1; cfg_div = 17'd5; cfg_dir = 1'b1;
      step(); step();
      idle_inputs();
      chk("hold2_running", 32'(running), 32'd0);
      start = 1'b1;
      step();
      idle_inputs();
      chk("resume_running", 32'(running), 32'd1);
      for (int i = 1; i <= 6; i++) begin
         step();
         chk("resume_tick", 32'(tick), 32'(i == 6));
      end
      chk("resume_leds", 32'(leds), 32'd1);

      // ---------------- wrap: down from 0, then up through FF
      clear = 1'b1;
      step();
      idle_inputs();
      cfg_valid = 1'b1; cfg_div = 17'd0; cfg_dir = 1'b0; start = 1'b1;
      step();
      idle_inputs();
      step();
      chk("dn_leds", 32'(leds), 32'hFF);
      chk("dn_tick", 32'(tick), 32'd1);
      chk("dn_wrap", 32'(wrap), 32'd1);
      step();
      chk("dn2_leds", 32'(leds), 32'hFE);
      chk("dn2_tick", 32'(tick), 32'd1);
      chk("dn2_wrap", 32'(wrap), 32'd0);
      stop = 1'b1;
      step();
      idle_inputs();
      chk("dn_stop_tick", 32'(tick), 32'd0);
      chk("dn_stop_leds", 32'(leds), 32'hFE);
      cfg_valid = 1'b1; cfg_div = 17'd0; cfg_dir = 1'b1; start = 1'b1;
      step();
      idle_inputs();
      step();
      chk("up_leds", 32'(leds), 32'hFF);
      chk("up_wrap", 32'(wrap), 32'd0);
      step();
      chk("upw_leds", 32'(leds), 32'h00);
      chk("upw_tick", 32'(tick), 32'd1);
      chk("upw_wrap", 32'(wrap), 32'd1);
      step();
      chk("upw2_leds", 32'(leds), 32'h01);
      chk("upw2_wrap", 32'(wrap), 32'd0);

      // ---------------- async reset mid-RUN, dir down, leds=5
      step(); step(); step(); step();
      chk("pre_rst_leds", 32'(leds), 32'd5);
      stop = 1'b1;
      step();
      idle_inputs();
      cfg_valid = 1'b1; cfg_div = 17'd2; cfg_dir = 1'b0; start = 1'b1;
      step();
      idle_inputs();
      step();
      chk("pre_rst_running", 32'(running), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("arst_leds",    32'(leds),      32'd0);
      chk("arst_running", 32'(running),   32'd0);
      chk("arst_tick",    32'(tick),      32'd0);
      chk("arst_wrap",    32'(wrap),      32'd0);
      chk("arst_ready",   32'(cfg_ready), 32'd1);
      #1 rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("after_rst_tick",    32'(tick),    32'd0);
         chk("after_rst_running", 32'(running), 32'd0);
      end
      start = 1'b1;
      step();
      idle_inputs();
      chk("restart_running", 32'(running), 32'd1);
      step(); step(); step();
      chk("restart_tick", 32'(tick), 32'd0);
      chk("restart_leds", 32'(leds), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/led_counter_ctrl.md
LED_COUNTER_CTRL -- requirements
Module: led_counter_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: LED counter width.
REQ-002 SHALL have parameter DIV_W, default 17: divider register width.
REQ-003 SHALL have parameter DEFAULT_DIV, default 17'd99999: divider terminal value loaded at reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cfg_valid  input  1  configuration request.
REQ-007 SHALL have port cfg_ready  output  1  configuration can be accepted.
REQ-008 SHALL have port cfg_div  input  DIV_W  requested divider terminal value.
REQ-009 SHALL have port cfg_dir  input  1  requested count direction: 1 = up, 0 = down.
REQ-010 SHALL have port start  input  1  run request.
REQ-011 SHALL have port stop  input  1  pause request.
REQ-012 SHALL have port clear  input  1  return-to-idle request.
REQ-013 SHALL have port tick  output  1  one-cycle pulse per divided period.
REQ-014 SHALL have port leds  output  CNT_W  LED counter value.
REQ-015 SHALL have port wrap  output  1  one-cycle pulse when leds wraps.
REQ-016 SHALL have port running  output  1  high while in state RUN.

Function
REQ-017 SHALL implement an FSM with states IDLE, RUN and HOLD.
REQ-018 SHALL give same-edge requests the priority clear > stop > start.
REQ-019 clear SHALL, from any state, force IDLE, leds=0, div_cnt=0, tick=0 and wrap=0; div_reg and dir_reg SHALL be retained.
REQ-020 start in IDLE SHALL enter RUN with div_cnt=0.
REQ-021 start in HOLD SHALL enter RUN with div_cnt unchanged (resume).
REQ-022 start in RUN SHALL be ignored.
REQ-023 stop in RUN SHALL enter HOLD; on that edge there SHALL be no tick and no count, and div_cnt SHALL be held.
REQ-024 stop in IDLE or HOLD SHALL be ignored.
REQ-025 cfg_ready SHALL be 1 in IDLE and HOLD and 0 in RUN; it SHALL be combinational from state.
REQ-026 A config transfer SHALL occur on an edge where cfg_valid=1 and cfg_ready=1: div_reg<=cfg_div, dir_reg<=cfg_dir, div_cnt<=0.
REQ-027 cfg_valid while cfg_ready=0 SHALL have no effect.
REQ-028 A transfer coinciding with start SHALL be accepted; the new div_reg SHALL govern the first RUN period.
REQ-029 In RUN, div_cnt SHALL increment each edge while div_cnt != div_reg.
REQ-030 On a RUN edge with div_cnt == div_reg: div_cnt<=0, tick<=1, and leds<=leds+1 (dir_reg=1) or leds-1 (dir_reg=0), modulo 2^CNT_W.
REQ-031 tick period SHALL be exactly div_reg+1 cycles; div_reg=0 SHALL give tick high every RUN cycle.
REQ-032 The first tick after IDLE->RUN SHALL be visible div_reg+1 cycles after running rises.
REQ-033 wrap SHALL be registered with tick: 1 when up-count leaves all-ones or down-count leaves zero, otherwise 0.
REQ-034 tick and wrap SHALL be 0 on every edge not covered by REQ-030.
REQ-035 tick, wrap and the new leds value SHALL be visible in the same cycle.
REQ-036 running SHALL be a registered decode of state == RUN.
REQ-037 All outputs except cfg_ready SHALL be registered.

Reset
REQ-038 rst=0 SHALL asynchronously force state=IDLE, div_cnt=0, div_reg=DEFAULT_DIV, dir_reg=1, leds=0, tick=0, wrap=0, running=0, cfg_ready=1.
REQ-039 Reset asserted mid-RUN SHALL abort immediately with no further tick.
REQ-040 The first edge after rst is released SHALL be treated as normal operation.

Verification
REQ-041 Reset, then cfg_div=3, cfg_dir=1 with start on the same edge -> running=1; tick on the 4th, 8th and 12th following edges; leds=1,2,3.
REQ-042 leds=8'hFF, dir up, div=0 -> next edge leds=0, tick=1, wrap=1; following edge leds=1, wrap=0.
REQ-043 Up to HOLD with div_cnt=2 (div=5), cfg_valid held while stopped -> config accepted, div_cnt=0; then start -> next tick after 6 cycles.
REQ-044 stop and clear on the same RUN edge -> IDLE, leds=0, no tick.
REQ-045 cfg_valid with cfg_div=7 during RUN -> cfg_ready=0, div_reg unchanged, tick period unchanged.
REQ-046 rst pulsed low between clock edges during RUN, dir down, leds=5 -> outputs immediately at reset values; no tick after release until start.
